// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared register-file widths and writeback request type
package core_pkg;

   localparam int REG_ADDR_SIZE  = 5;
   localparam int REG_DATA_WIDTH = 32;
   localparam int WB_NUM_REQ     = 3;

   typedef struct packed {
      logic                      we;
      logic [REG_ADDR_SIZE-1:0]  waddr;
      logic [REG_DATA_WIDTH-1:0] wdata;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin scan starting at ptr_i
module rr_arbiter #(
   parameter  int N  = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic          en_i,
   output logic [N-1:0]  gnt_onehot_o,
   output logic [IW-1:0] gnt_idx_o,
   output logic          gnt_valid_o,
   output logic [IW-1:0] next_ptr_o
);

   logic          found;
   logic [IW:0]   idx;
   logic [IW-1:0] sel;

   always_comb begin
      found     = 1'b0;
      gnt_idx_o = '0;
      idx       = '0;
      sel       = '0;
      // Explicit modulo wrap keeps non-power-of-2 N correct.
      for (int i = 0; i < N; i++) begin
         idx = {1'b0, ptr_i} + (IW+1)'(i);
         if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
         sel = idx[IW-1:0];
         if (!found && req_i[sel]) begin
            found     = 1'b1;
            gnt_idx_o = sel;
         end
      end
   end

   always_comb begin
      gnt_onehot_o = '0;
      gnt_valid_o  = found & en_i;
      if (gnt_valid_o) gnt_onehot_o[gnt_idx_o] = 1'b1;
      next_ptr_o = (gnt_idx_o == IW'(N-1)) ? '0 : gnt_idx_o + IW'(1);
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin share of the commit-stage regfile write port
module wb_port_arbiter #(
   parameter  int NUM_REQ        = core_pkg::WB_NUM_REQ,
   parameter  int REG_ADDR_SIZE  = core_pkg::REG_ADDR_SIZE,
   parameter  int REG_DATA_WIDTH = core_pkg::REG_DATA_WIDTH,
   localparam int IW             = $clog2(NUM_REQ)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              flush_i,
   input  logic [NUM_REQ-1:0]                req_valid_i,
   output logic [NUM_REQ-1:0]                req_ready_o,
   input  logic [NUM_REQ*REG_ADDR_SIZE-1:0]  req_waddr_i,
   input  logic [NUM_REQ*REG_DATA_WIDTH-1:0] req_wdata_i,
   input  logic                              commit_ack_i,
   output logic                              commit_regfile_we_o,
   output logic [REG_ADDR_SIZE-1:0]          commit_regfile_waddr_o,
   output logic [REG_DATA_WIDTH-1:0]         commit_regfile_wdata_o,
   output logic [IW-1:0]                     grant_id_o
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]                state_q, state_d;
   logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]             gid_q, gid_d;
   logic [REG_ADDR_SIZE-1:0]  waddr_q, waddr_d;
   logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic                      can_accept;
   logic                      arb_en;
   logic                      fire;
   logic [IW-1:0]             gnt_idx;
   logic [IW-1:0]             next_ptr;
   logic [REG_ADDR_SIZE-1:0]  win_waddr;
   logic [REG_DATA_WIDTH-1:0] win_wdata;

   // Ack frees the slot in the same cycle, so a new winner loads with no bubble.
   assign can_accept = (state_q == ST_EMPTY) | commit_ack_i;
   assign arb_en     = can_accept & ~flush_i & rst_ni;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req_i        (req_valid_i),
      .ptr_i        (rr_ptr_q),
      .en_i         (arb_en),
      .gnt_onehot_o (req_ready_o),
      .gnt_idx_o    (gnt_idx),
      .gnt_valid_o  (fire),
      .next_ptr_o   (next_ptr)
   );

   assign win_waddr = req_waddr_i[gnt_idx*REG_ADDR_SIZE +: REG_ADDR_SIZE];
   assign win_wdata = req_wdata_i[gnt_idx*REG_DATA_WIDTH +: REG_DATA_WIDTH];

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gid_d    = gid_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else if (fire) begin
         rr_ptr_d = next_ptr;
         // Writes to x0 are consumed but never presented to the commit stage.
         if (win_waddr != '0) begin
            state_d = ST_FULL;
            gid_d   = gnt_idx;
            waddr_d = win_waddr;
            wdata_d = win_wdata;
         end else begin
            state_d = ST_EMPTY;
         end
      end else if (state_q == ST_FULL && commit_ack_i) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_EMPTY;
         rr_ptr_q <= '0;
         gid_q    <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gid_q    <= gid_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign commit_regfile_we_o    = (state_q == ST_FULL);
   assign commit_regfile_waddr_o = waddr_q;
   assign commit_regfile_wdata_o = wdata_q;
   assign grant_id_o             = gid_q;

   a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(req_ready_o));

   a_hold_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == ST_FULL && !commit_ack_i && !flush_i) |=>
         (commit_regfile_we_o &&
          $stable({commit_regfile_waddr_o, commit_regfile_wdata_o, grant_id_o})));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - table-driven bench with commit scoreboard for wb_port_arbiter
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [2:0]  valid;
   logic [2:0]  ready;
   logic [14:0] waddr;
   logic [95:0] wdata;
   logic        ack;
   logic        we;
   logic [4:0]  o_waddr;
   logic [31:0] o_wdata;
   logic [1:0]  gid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_port_arbiter dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .flush_i                (flush),
      .req_valid_i            (valid),
      .req_ready_o            (ready),
      .req_waddr_i            (waddr),
      .req_wdata_i            (wdata),
      .commit_ack_i           (ack),
      .commit_regfile_we_o    (we),
      .commit_regfile_waddr_o (o_waddr),
      .commit_regfile_wdata_o (o_wdata),
      .grant_id_o             (gid)
   );

   typedef struct {
      logic        flush;
      logic [2:0]  valid;
      logic [4:0]  a0, a1, a2;
      logic [31:0] d0, d1, d2;
      logic        ack;
      logic [2:0]  rdy;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [1:0]  gid;
   } vec_t;

   typedef struct packed {
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [1:0]  gid;
   } sb_t;

   vec_t tv[$];
   sb_t  sb[$];

   localparam logic [31:0] D0 = 32'hA000_0001;
   localparam logic [31:0] D1 = 32'hA000_0002;
   localparam logic [31:0] D2 = 32'hA000_0003;

   function automatic vec_t mk(logic f, logic [2:0] v, logic [4:0] a0, logic [4:0] a1,
                               logic [4:0] a2, logic [31:0] d0, logic [31:0] d1,
                               logic [31:0] d2, logic k, logic [2:0] rdy, logic w,
                               logic [4:0] wa, logic [31:0] wd, logic [1:0] g);
      vec_t r;
      r.flush = f;  r.valid = v;  r.a0 = a0;  r.a1 = a1;  r.a2 = a2;
      r.d0 = d0;    r.d1 = d1;    r.d2 = d2;  r.ack = k;  r.rdy = rdy;
      r.we = w;     r.wa = wa;    r.wd = wd;  r.gid = g;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      flush = v.flush;
      valid = v.valid;
      waddr = {v.a2, v.a1, v.a0};
      wdata = {v.d2, v.d1, v.d0};
      ack   = v.ack;
   endtask

   task automatic sb_push(input vec_t v);
      sb_t e;
      if (v.flush || v.rdy == 3'b000) return;
      case (v.rdy)
         3'b001:  begin e.wa = v.a0; e.wd = v.d0; e.gid = 2'd0; end
         3'b010:  begin e.wa = v.a1; e.wd = v.d1; e.gid = 2'd1; end
         default: begin e.wa = v.a2; e.wd = v.d2; e.gid = 2'd2; end
      endcase
      if (e.wa != 5'd0) sb.push_back(e);
   endtask

   initial begin
      sb_t e;
      rst_n = 1'b0;
      flush = 1'b0;
      valid = 3'b111;
      waddr = '0;
      wdata = '0;
      ack   = 1'b0;

      // single write, then a req1 write and an x0 discard that returns rr_ptr to 0
      tv.push_back(mk(0,3'b001,5,0,0,32'hDEADBEEF,0,0,1, 3'b001,0,0,0,0));
      tv.push_back(mk(0,3'b000,0,0,0,0,0,0,1,            3'b000,1,5,32'hDEADBEEF,0));
      tv.push_back(mk(0,3'b000,0,0,0,0,0,0,1,            3'b000,0,0,0,0));
      tv.push_back(mk(0,3'b010,0,3,0,0,32'h1111_0003,0,1,3'b010,0,0,0,0));
      tv.push_back(mk(0,3'b000,0,0,0,0,0,0,1,            3'b000,1,3,32'h1111_0003,1));
      tv.push_back(mk(0,3'b100,0,0,0,0,0,32'h1234,1,     3'b100,0,0,0,0));
      tv.push_back(mk(0,3'b000,0,0,0,0,0,0,1,            3'b000,0,0,0,0));
      // round robin, all valid, no bubbles
      tv.push_back(mk(0,3'b111,1,2,3,D0,D1,D2,1, 3'b001,0,0,0,0));
      tv.push_back(mk(0,3'b111,1,2,3,D0,D1,D2,1, 3'b010,1,1,D0,0));
      tv.push_back(mk(0,3'b111,1,2,3,D0,D1,D2,1, 3'b100,1,2,D1,1));
      tv.push_back(mk(0,3'b111,1,2,3,D0,D1,D2,1, 3'b001,1,3,D2,2));
      tv.push_back(mk(0,3'b111,1,2,3,D0,D1,D2,1, 3'b010,1,1,D0,0));
      tv.push_back(mk(0,3'b111,1,2,3,D0,D1,D2,1, 3'b100,1,2,D1,1));
      tv.push_back(mk(0,3'b000,1,2,3,D0,D1,D2,1, 3'b000,1,3,D2,2));
      // backpressure: hold waddr=7 for four cycles while req1 waits
      tv.push_back(mk(0,3'b001,7,0,0,32'h77,0,0,0, 3'b001,0,0,0,0));
      for (int i = 0; i < 4; i++)
         tv.push_back(mk(0,3'b010,7,8,0,32'h77,32'h88,0,0, 3'b000,1,7,32'h77,0));
      tv.push_back(mk(0,3'b010,7,8,0,32'h77,32'h88,0,1, 3'b010,1,7,32'h77,0));
      tv.push_back(mk(0,3'b000,0,8,0,0,32'h88,0,1,      3'b000,1,8,32'h88,1));
      // ack while empty is ignored; flush drops the held waddr=9
      tv.push_back(mk(0,3'b100,0,0,9,0,0,32'h99,1,      3'b100,0,0,0,0));
      tv.push_back(mk(0,3'b000,0,0,9,0,0,32'h99,0,      3'b000,1,9,32'h99,2));
      tv.push_back(mk(1,3'b001,6,0,9,32'h66,0,32'h99,0, 3'b000,1,9,32'h99,2));
      tv.push_back(mk(0,3'b001,6,0,0,32'h66,0,0,1,      3'b001,0,0,0,0));
      tv.push_back(mk(0,3'b000,6,0,0,32'h66,0,0,1,      3'b000,1,6,32'h66,0));

      #1;
      chk("rst_we", {63'd0, we}, 64'd0);
      chk("rst_waddr", {59'd0, o_waddr}, 64'd0);
      chk("rst_wdata", {32'd0, o_wdata}, 64'd0);
      chk("rst_gid", {62'd0, gid}, 64'd0);
      chk("rst_ready", {61'd0, ready}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (tv[i]) begin
         @(posedge clk);
         #1;
         drive(tv[i]);
         sb_push(tv[i]);
         @(negedge clk);
         chk($sformatf("v%0d_ready", i), {61'd0, ready}, {61'd0, tv[i].rdy});
         chk($sformatf("v%0d_we", i), {63'd0, we}, {63'd0, tv[i].we});
         if (tv[i].we) begin
            chk($sformatf("v%0d_waddr", i), {59'd0, o_waddr}, {59'd0, tv[i].wa});
            chk($sformatf("v%0d_wdata", i), {32'd0, o_wdata}, {32'd0, tv[i].wd});
            chk($sformatf("v%0d_gid", i), {62'd0, gid}, {62'd0, tv[i].gid});
         end
         if (tv[i].flush && tv[i].we && sb.size() > 0) void'(sb.pop_front());
         if (we && tv[i].ack && !tv[i].flush) begin
            if (sb.size() == 0) begin
               chk($sformatf("v%0d_sb_unexpected", i), 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk($sformatf("v%0d_sb_commit", i), {25'd0, o_waddr, o_wdata, gid},
                   {25'd0, e.wa, e.wd, e.gid});
            end
         end
      end
      chk("sb_drained", 64'(sb.size()), 64'd0);

      // asynchronous reset while FULL with waddr=4
      @(posedge clk);
      #1;
      flush = 1'b0; ack = 1'b0; valid = 3'b010;
      waddr = {5'd0, 5'd4, 5'd12}; wdata = {32'd0, 32'h44, 32'hC0C0};
      @(negedge clk);
      chk("ar_ready", {61'd0, ready}, 64'd2);
      @(posedge clk);
      #1;
      valid = 3'b000;
      @(negedge clk);
      chk("ar_full_waddr", {59'd0, o_waddr}, 64'd4);
      #2;
      rst_n = 1'b0;
      valid = 3'b111;
      #1;
      chk("ar_we", {63'd0, we}, 64'd0);
      chk("ar_waddr", {59'd0, o_waddr}, 64'd0);
      chk("ar_wdata", {32'd0, o_wdata}, 64'd0);
      chk("ar_gid", {62'd0, gid}, 64'd0);
      chk("ar_ready_in_reset", {61'd0, ready}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ack   = 1'b1;
      #1;
      chk("ar_first_ready", {61'd0, ready}, 64'd1);
      @(posedge clk);
      #1;
      valid = 3'b000;
      @(negedge clk);
      chk("ar_first_we", {63'd0, we}, 64'd1);
      chk("ar_first_waddr", {59'd0, o_waddr}, 64'd12);
      chk("ar_first_gid", {62'd0, gid}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
